// File: rtl/fpu_issue_scoreboard_if.sv
// Issue/writeback bundle between FP decode, the FPU issue scoreboard and the FP register file.
interface fpu_issue_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int LAT_W = 4
);
    localparam int RW = $clog2(NREG);

    logic              issue_valid;
    logic              issue_ready;
    logic [RW-1:0]     rs1i;
    logic [RW-1:0]     rs2i;
    logic [RW-1:0]     rs3i;
    logic              use_rs1;
    logic              use_rs2;
    logic              use_rs3;
    logic [RW-1:0]     rdi;
    logic              rd_write;
    logic [LAT_W-1:0]  lat;
    logic              is_iter;
    logic              flush;
    logic              wb_valid;
    logic [RW-1:0]     wb_rd;
    logic [NREG-1:0]   busy_vec;
    logic [2:0]        stall_cause;

    modport master (
        output issue_valid, rs1i, rs2i, rs3i, use_rs1, use_rs2, use_rs3,
               rdi, rd_write, lat, is_iter, flush,
        input  issue_ready, wb_valid, wb_rd, busy_vec, stall_cause
    );

    modport slave (
        input  issue_valid, rs1i, rs2i, rs3i, use_rs1, use_rs2, use_rs3,
               rdi, rd_write, lat, is_iter, flush,
        output issue_ready, wb_valid, wb_rd, busy_vec, stall_cause
    );
endinterface

// File: rtl/fpu_issue_scoreboard.sv
// FPU issue scoreboard: holds an FP op until RAW/WAW, writeback-port and iterative-unit
// hazards clear, and sequences FP register-file writes through a reservation shift register.
module fpu_issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int LAT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_issue_scoreboard_if.slave bus
);
    localparam int MAXL = (1 << LAT_W) - 1;
    localparam int RW   = $clog2(NREG);

    // Slot k holds the op that writes back k cycles from now; slot 1 is this cycle's write.
    logic [MAXL:1]    v_q, v_d;
    logic [RW-1:0]    rd_q [1:MAXL];
    logic [RW-1:0]    rd_d [1:MAXL];
    logic [LAT_W-1:0] iter_cnt_q, iter_cnt_d;

    logic [LAT_W-1:0] lat_eff;
    logic [NREG-1:0]  busy;
    logic             raw, waw, wb_conflict, iter_conflict;
    logic             ready, accept;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        lat_eff = (bus.lat == '0) ? LAT_W'(1) : bus.lat;

        busy = '0;
        for (int k = 1; k <= MAXL; k++) begin
            if (v_q[k]) busy[rd_q[k]] = 1'b1;
        end

        raw = (bus.use_rs1 & busy[bus.rs1i]) |
              (bus.use_rs2 & busy[bus.rs2i]) |
              (bus.use_rs3 & busy[bus.rs3i]);
        waw = bus.rd_write & busy[bus.rdi];

        // Slot L+1 shifts into slot L on this edge; L = MAXL has no such neighbour.
        wb_conflict = 1'b0;
        for (int k = 1; k < MAXL; k++) begin
            if (int'(lat_eff) == k) wb_conflict = bus.rd_write & v_q[k+1];
        end

        iter_conflict = bus.is_iter & (iter_cnt_q != '0);
        ready  = ~bus.flush & ~(raw | waw | wb_conflict | iter_conflict);
        accept = bus.issue_valid & ready;

        for (int k = 1; k < MAXL; k++) begin
            v_d[k]  = v_q[k+1];
            rd_d[k] = rd_q[k+1];
        end
        v_d[MAXL]  = 1'b0;
        rd_d[MAXL] = '0;

        if (accept && bus.rd_write) begin
            for (int k = 1; k <= MAXL; k++) begin
                if (int'(lat_eff) == k) begin
                    v_d[k]  = 1'b1;
                    rd_d[k] = bus.rdi;
                end
            end
        end

        // Counter holds remaining blocked cycles, so a successor issues in the predecessor's wb cycle.
        iter_cnt_d = iter_cnt_q;
        if (iter_cnt_q != '0) iter_cnt_d = iter_cnt_q - LAT_W'(1);
        if (accept && bus.is_iter) iter_cnt_d = lat_eff - LAT_W'(1);

        if (bus.flush) begin
            v_d        = '0;
            iter_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q        <= '0;
            iter_cnt_q <= '0;
        end else begin
            v_q        <= v_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    // NOTE: the rd payload is not reset; it is only observed when its valid bit is set.
    always_ff @(posedge clk) begin
        for (int k = 1; k <= MAXL; k++) begin
            rd_q[k] <= rd_d[k];
        end
    end

    assign bus.issue_ready = ready;
    assign bus.wb_valid    = v_q[1];
    assign bus.wb_rd       = v_q[1] ? rd_q[1] : '0;
    assign bus.busy_vec    = busy;
    assign bus.stall_cause = {iter_conflict, wb_conflict, raw | waw} &
                             {3{bus.issue_valid & ~bus.flush}};
endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Self-checking bench for fpu_issue_scoreboard: hazard vector table, hand-written
// multi-cycle sequences and a writeback scoreboard queue.
module tb_fpu_issue_scoreboard;
    localparam int NREG  = 32;
    localparam int LAT_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #50 clk = ~clk;

    fpu_issue_scoreboard_if #(.NREG(NREG), .LAT_W(LAT_W)) sif ();

    fpu_issue_scoreboard #(.NREG(NREG), .LAT_W(LAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] rd;
        logic [3:0] lat;
        logic       w;
        logic       it;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rs3;
        logic       u3;
    } op_t;

    typedef struct {
        string      name;
        logic       valid;
        logic       flush;
        op_t        op;
        logic       exp_ready;
        logic [2:0] exp_stall;
    } vec_t;

    typedef struct {
        int         due;
        logic [4:0] rd;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    vec_t    vt[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic op_t mk_op(input logic [4:0] rd, input logic [3:0] lat, input logic w,
                                  input logic it, input logic [4:0] rs1 = 0, input logic u1 = 0,
                                  input logic [4:0] rs2 = 0, input logic u2 = 0,
                                  input logic [4:0] rs3 = 0, input logic u3 = 0);
        op_t o;
        o.rd = rd; o.lat = lat; o.w = w; o.it = it;
        o.rs1 = rs1; o.u1 = u1; o.rs2 = rs2; o.u2 = u2; o.rs3 = rs3; o.u3 = u3;
        return o;
    endfunction

    task automatic drive(input op_t o, input logic valid);
        sif.issue_valid = valid;
        sif.rdi = o.rd;       sif.lat = o.lat;
        sif.rd_write = o.w;   sif.is_iter = o.it;
        sif.rs1i = o.rs1;     sif.use_rs1 = o.u1;
        sif.rs2i = o.rs2;     sif.use_rs2 = o.u2;
        sif.rs3i = o.rs3;     sif.use_rs3 = o.u3;
    endtask

    task automatic idle();
        drive(mk_op(0, 0, 0, 0), 1'b0);
        sif.flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Writeback monitor: every cycle compares wb against the scoreboard, then records accepts.
    always @(negedge clk) begin
        int idx;
        if (rst) begin
            exp_q.delete();
        end else begin
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].due == cyc) idx = i;
            end
            check("wb_valid", {31'b0, sif.wb_valid}, {31'b0, idx >= 0});
            if (idx >= 0) begin
                check("wb_rd", {27'b0, sif.wb_rd}, {27'b0, exp_q[idx].rd});
                exp_q.delete(idx);
            end else begin
                check("wb_rd_idle", {27'b0, sif.wb_rd}, 32'd0);
            end
            if (sif.flush) begin
                exp_q.delete();
            end else if (sif.issue_valid && sif.issue_ready && sif.rd_write) begin
                exp_q.push_back('{cyc + ((sif.lat == 0) ? 1 : int'(sif.lat)), sif.rdi});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1);
    end

    initial begin
        int t0;
        rst = 1'b1;
        idle();

        // Reset state
        do_reset();
        check("rst_ready", {31'b0, sif.issue_ready}, 32'd1);
        check("rst_wb_valid", {31'b0, sif.wb_valid}, 32'd0);
        check("rst_wb_rd", {27'b0, sif.wb_rd}, 32'd0);
        check("rst_busy", sif.busy_vec, 32'd0);
        check("rst_stall", {29'b0, sif.stall_cause}, 32'd0);

        // Hazard table; state at probe time: rd=3 pending in slot 4, iterative unit busy 3 more cycles
        vt[0]  = '{"raw_rs1",     1'b1, 1'b0, mk_op(8, 1, 0, 0, 3, 1),             1'b0, 3'b001};
        vt[1]  = '{"rs1_unused",  1'b1, 1'b0, mk_op(8, 1, 0, 0, 3, 0),             1'b1, 3'b000};
        vt[2]  = '{"raw_rs2",     1'b1, 1'b0, mk_op(8, 1, 0, 0, 0, 0, 3, 1),       1'b0, 3'b001};
        vt[3]  = '{"raw_rs3",     1'b1, 1'b0, mk_op(8, 1, 0, 0, 0, 0, 0, 0, 3, 1), 1'b0, 3'b001};
        vt[4]  = '{"waw",         1'b1, 1'b0, mk_op(3, 1, 1, 0),                   1'b0, 3'b001};
        vt[5]  = '{"nowrite_rd3", 1'b1, 1'b0, mk_op(3, 3, 0, 0),                   1'b1, 3'b000};
        vt[6]  = '{"wb_slot",     1'b1, 1'b0, mk_op(8, 3, 1, 0),                   1'b0, 3'b010};
        vt[7]  = '{"wb_lat4",     1'b1, 1'b0, mk_op(8, 4, 1, 0),                   1'b1, 3'b000};
        vt[8]  = '{"lat_max",     1'b1, 1'b0, mk_op(8, 15, 1, 0),                  1'b1, 3'b000};
        vt[9]  = '{"iter_busy",   1'b1, 1'b0, mk_op(8, 5, 0, 1),                   1'b0, 3'b100};
        vt[10] = '{"all_three",   1'b1, 1'b0, mk_op(8, 3, 1, 1, 3, 1),             1'b0, 3'b111};
        vt[11] = '{"no_valid",    1'b0, 1'b0, mk_op(8, 3, 1, 1, 3, 1),             1'b0, 3'b000};
        vt[12] = '{"flush_hold",  1'b1, 1'b1, mk_op(8, 1, 1, 0),                   1'b0, 3'b000};
        vt[13] = '{"lat0",        1'b1, 1'b0, mk_op(8, 0, 1, 0),                   1'b1, 3'b000};
        vt[14] = '{"lat0_iter",   1'b1, 1'b0, mk_op(8, 0, 0, 1),                   1'b0, 3'b100};

        do_reset();
        drive(mk_op(3, 4, 1, 1), 1'b1);
        #1 check("tbl_setup_ready", {31'b0, sif.issue_ready}, 32'd1);
        step();
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].op, vt[i].valid);
            sif.flush = vt[i].flush;
            #1;
            check({vt[i].name, "_ready"}, {31'b0, sif.issue_ready}, {31'b0, vt[i].exp_ready});
            check({vt[i].name, "_stall"}, {29'b0, sif.stall_cause}, {29'b0, vt[i].exp_stall});
            #1;
        end
        idle();
        #1 check("tbl_busy", sif.busy_vec, 32'h0000_0008);
        repeat (6) step();

        // RAW sequence: rd=3 lat=4 in cycle 0, dependent reader stalls cycles 1-4
        do_reset();
        t0 = cyc;
        drive(mk_op(3, 4, 1, 0), 1'b1);
        #1 check("raw_seq_issue", {31'b0, sif.issue_ready}, 32'd1);
        step();
        for (int c = 1; c <= 4; c++) begin
            drive(mk_op(8, 1, 0, 0, 3, 1), 1'b1);
            #1;
            check("raw_seq_ready", {31'b0, sif.issue_ready}, 32'd0);
            check("raw_seq_stall", {29'b0, sif.stall_cause}, 32'd1);
            check("raw_seq_busy3", {31'b0, sif.busy_vec[3]}, 32'd1);
            check("raw_seq_wb", {31'b0, sif.wb_valid}, {31'b0, (cyc - t0) == 4});
            step();
        end
        drive(mk_op(8, 1, 0, 0, 3, 1), 1'b1);
        #1;
        check("raw_seq_release", {31'b0, sif.issue_ready}, 32'd1);
        check("raw_seq_busy_clear", sif.busy_vec, 32'd0);
        step();
        idle();
        step();

        // Writeback port sequence
        do_reset();
        drive(mk_op(1, 4, 1, 0), 1'b1);
        #1 check("wbp_a_ready", {31'b0, sif.issue_ready}, 32'd1);
        step();
        drive(mk_op(2, 3, 1, 0), 1'b1);
        #1;
        check("wbp_b3_ready", {31'b0, sif.issue_ready}, 32'd0);
        check("wbp_b3_stall", {29'b0, sif.stall_cause}, 32'd2);
        drive(mk_op(2, 2, 1, 0), 1'b1);
        #1 check("wbp_b2_ready", {31'b0, sif.issue_ready}, 32'd1);
        step();
        idle();
        step();
        check("wbp_c3_valid", {31'b0, sif.wb_valid}, 32'd1);
        check("wbp_c3_rd", {27'b0, sif.wb_rd}, 32'd2);
        step();
        check("wbp_c4_valid", {31'b0, sif.wb_valid}, 32'd1);
        check("wbp_c4_rd", {27'b0, sif.wb_rd}, 32'd1);
        step();
        check("wbp_c5_valid", {31'b0, sif.wb_valid}, 32'd0);

        // Iterative unit sequence
        do_reset();
        drive(mk_op(5, 12, 1, 1), 1'b1);
        #1 check("iter_div_ready", {31'b0, sif.issue_ready}, 32'd1);
        step();
        drive(mk_op(7, 3, 1, 0), 1'b1);
        #1 check("iter_fadd_ready", {31'b0, sif.issue_ready}, 32'd1);
        step();
        for (int c = 2; c <= 11; c++) begin
            drive(mk_op(6, 12, 1, 1), 1'b1);
            #1;
            check("iter_sqrt_ready", {31'b0, sif.issue_ready}, 32'd0);
            check("iter_sqrt_stall", {29'b0, sif.stall_cause}, 32'd4);
            step();
        end
        drive(mk_op(6, 12, 1, 1), 1'b1);
        #1;
        check("iter_sqrt_c12_ready", {31'b0, sif.issue_ready}, 32'd1);
        check("iter_sqrt_c12_wb", {27'b0, sif.wb_rd}, 32'd5);
        step();
        idle();
        repeat (14) step();

        // Flush sequence
        do_reset();
        drive(mk_op(11, 6, 1, 0), 1'b1);
        #1 check("fl_a_ready", {31'b0, sif.issue_ready}, 32'd1);
        step();
        drive(mk_op(12, 3, 1, 0), 1'b1);
        #1 check("fl_b_ready", {31'b0, sif.issue_ready}, 32'd1);
        step();
        drive(mk_op(13, 2, 1, 0), 1'b1);
        sif.flush = 1'b1;
        #1;
        check("fl_ready", {31'b0, sif.issue_ready}, 32'd0);
        check("fl_stall", {29'b0, sif.stall_cause}, 32'd0);
        check("fl_busy_before", sif.busy_vec, 32'h0000_1800);
        step();
        idle();
        check("fl_busy_after", sif.busy_vec, 32'd0);
        check("fl_wb_after", {31'b0, sif.wb_valid}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            step();
            check("fl_no_late_wb", {31'b0, sif.wb_valid}, 32'd0);
        end

        // lat=0 and lat=MAXL boundaries
        do_reset();
        drive(mk_op(9, 0, 1, 0), 1'b1);
        #1 check("lat0_ready", {31'b0, sif.issue_ready}, 32'd1);
        step();
        idle();
        check("lat0_wb_valid", {31'b0, sif.wb_valid}, 32'd1);
        check("lat0_wb_rd", {27'b0, sif.wb_rd}, 32'd9);
        check("lat0_busy", sif.busy_vec, 32'h0000_0200);
        step();
        check("lat0_done", {31'b0, sif.wb_valid}, 32'd0);
        drive(mk_op(14, 15, 1, 0), 1'b1);
        #1 check("lat15_a_ready", {31'b0, sif.issue_ready}, 32'd1);
        step();
        drive(mk_op(15, 15, 1, 0), 1'b1);
        #1;
        check("lat15_b_ready", {31'b0, sif.issue_ready}, 32'd1);
        check("lat15_b_stall", {29'b0, sif.stall_cause}, 32'd0);
        step();
        idle();
        repeat (17) step();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
